// File: rtl/pattern_pwm.sv
// pattern_pwm: pattern-driven PWM burst generator.
// A start request captures a pattern and a repeat count. The pattern is then
// shifted out MSB-first, one bit per clock, duty_num + 1 times back to back.
// busy marks the burst and valid pulses for one cycle when it completes.
// Note: rst_n is active-high despite its name.

module pattern_pwm #(
   parameter int _PAT_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pwm_en,
   input  logic [7:0]            duty_num,
   input  logic [_PAT_WIDTH-1:0] PAT,
   output logic                  pwm_out,
   output logic                  busy,
   output logic                  valid
);

   localparam int W     = _PAT_WIDTH;
   localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);
   localparam logic [IDX_W-1:0] IDX_ZERO = '0;
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [7:0]       REP_ONE  = 8'd1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     pat_q, pat_d;
   logic [7:0]       dup_q, dup_d;
   logic [7:0]       rep_q, rep_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             pwm_out_q, pwm_out_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;

   // Next-state and next-output logic; idx_q always names the bit currently on pwm_out
   always_comb begin
      state_d   = state_q;
      pat_d     = pat_q;
      dup_d     = dup_q;
      rep_d     = rep_q;
      idx_d     = idx_q;
      pwm_out_d = 1'b0;
      busy_d    = 1'b0;
      valid_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (pwm_en) begin
               pat_d     = PAT;
               dup_d     = duty_num;
               rep_d     = 8'd0;
               idx_d     = IDX_LAST;
               state_d   = RUN;
               pwm_out_d = PAT[W-1];
               busy_d    = 1'b1;
            end
         end

         RUN: begin
            if (idx_q != IDX_ZERO) begin
               idx_d     = idx_q - IDX_ONE;
               pwm_out_d = pat_q[idx_d];
               busy_d    = 1'b1;
            end else if (rep_q < dup_q) begin
               rep_d     = rep_q + REP_ONE;
               idx_d     = IDX_LAST;
               pwm_out_d = pat_q[W-1];
               busy_d    = 1'b1;
            end else begin
               state_d = DONE;
               valid_d = 1'b1;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; an asserted reset aborts any burst without a valid pulse
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Captured pattern, repeat limit and position counters
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         pat_q <= '0;
         dup_q <= 8'd0;
         rep_q <= 8'd0;
         idx_q <= '0;
      end else begin
         pat_q <= pat_d;
         dup_q <= dup_d;
         rep_q <= rep_d;
         idx_q <= idx_d;
      end
   end

   // Registered outputs so no input reaches a pin combinationally
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         pwm_out_q <= 1'b0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         pwm_out_q <= pwm_out_d;
         busy_q    <= busy_d;
         valid_q   <= valid_d;
      end
   end

   assign pwm_out = pwm_out_q;
   assign busy    = busy_q;
   assign valid   = valid_q;

endmodule

// File: tb/tb_pattern_pwm.sv
// tb_pattern_pwm: scoreboard bench for pattern_pwm.
// The stimulus side pushes the expected per-cycle outputs of every burst it
// starts; a monitor pops one entry per cycle and compares, or expects all
// outputs low when nothing is outstanding.

module tb_pattern_pwm;

   localparam int W = 16;

   typedef struct packed {
      logic pwm;
      logic busy;
      logic valid;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         pwm_en;
   logic [7:0]   duty_num;
   logic [W-1:0] PAT;
   logic         pwm_out;
   logic         busy;
   logic         valid;

   exp_t exp_q[$];
   int   checks;
   int   failures;

   pattern_pwm #(._PAT_WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pwm_en   (pwm_en),
      .duty_num (duty_num),
      .PAT      (PAT),
      .pwm_out  (pwm_out),
      .busy     (busy),
      .valid    (valid)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic exp_t mkExp(input logic p, input logic b, input logic v);
      exp_t e;
      e.pwm   = p;
      e.busy  = b;
      e.valid = v;
      return e;
   endfunction

   // Reference: the pattern played n+1 times MSB-first, then one valid cycle
   task automatic pushBurst(input logic [W-1:0] pat, input int n);
      for (int r = 0; r <= n; r++) begin
         for (int k = W - 1; k >= 0; k--) begin
            exp_q.push_back(mkExp(pat[k], 1'b1, 1'b0));
         end
      end
      exp_q.push_back(mkExp(1'b0, 1'b0, 1'b1));
   endtask

   task automatic checkOutput(input string name, input exp_t expv, input exp_t act);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("[TB] FAIL %s t=%0t actual(pwm,busy,valid)=%b required=%b",
                  name, $time, act, expv);
      end
   endtask

   // Wait until every expected entry has been consumed, optionally jiggling inputs mid-burst
   task automatic waitDrain(input int budget, input bit noise);
      int cyc;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (noise && exp_q.size() >= 2) begin
            pwm_en   = 1'($urandom);
            PAT      = W'($urandom);
            duty_num = 8'($urandom);
         end
      end
      pwm_en = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain_timeout t=%0t actual_pending=%0d required_pending=0",
                  $time, exp_q.size());
         exp_q.delete();
      end
   endtask

   // Issue one single-cycle start and follow the burst to completion
   task automatic applyStimulus(input logic [W-1:0] pat, input int n, input bit noise);
      @(negedge clk);
      pwm_en   = 1'b1;
      PAT      = pat;
      duty_num = 8'(n);
      pushBurst(pat, n);
      @(negedge clk);
      pwm_en   = 1'b0;
      PAT      = W'($urandom);
      duty_num = 8'($urandom);
      waitDrain(W * (n + 1) + 20, noise);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         PAT      = W'($urandom);
         duty_num = 8'($urandom);
      end
   endtask

   // Monitor: one comparison per cycle, sampled just after the rising edge
   initial begin
      exp_t act;
      forever begin
         @(posedge clk);
         #1;
         act = mkExp(pwm_out, busy, valid);
         if (exp_q.size() > 0) begin
            checkOutput("burst_out", exp_q.pop_front(), act);
         end else begin
            checkOutput("idle_out", mkExp(1'b0, 1'b0, 1'b0), act);
         end
      end
   end

   // Directed and randomized stimulus
   initial begin
      logic [W-1:0] rpat;
      int           rdup;

      checks   = 0;
      failures = 0;
      rst_n    = 1'b1;
      pwm_en   = 1'b0;
      PAT      = '0;
      duty_num = 8'd0;

      // Reset held with random inputs, outputs must stay low
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         pwm_en   = 1'($urandom);
         PAT      = W'($urandom);
         duty_num = 8'($urandom);
      end
      @(negedge clk);
      rst_n  = 1'b0;
      pwm_en = 1'b0;
      idleCycles(4);

      applyStimulus(16'hAAAA, 0, 1'b0);
      idleCycles(2);
      applyStimulus(16'h0000, 0, 1'b0);
      idleCycles(2);
      applyStimulus(16'hFFFF, 2, 1'b0);
      idleCycles(2);
      applyStimulus(16'h8001, 1, 1'b1);
      idleCycles(3);

      // Held-high start: a second burst follows one idle cycle after DONE
      @(negedge clk);
      rpat     = W'($urandom);
      pwm_en   = 1'b1;
      PAT      = rpat;
      duty_num = 8'd0;
      pushBurst(rpat, 0);
      exp_q.push_back(mkExp(1'b0, 1'b0, 1'b0));
      pushBurst(rpat, 0);
      waitDrain(80, 1'b0);
      idleCycles(3);

      // Randomized bursts with input noise while busy
      for (int t = 0; t < 8; t++) begin
         rpat = W'($urandom);
         rdup = int'($urandom_range(0, 3));
         applyStimulus(rpat, rdup, 1'b1);
         idleCycles(int'($urandom_range(0, 3)));
      end

      // Reset mid-burst aborts immediately with no valid
      @(negedge clk);
      rpat     = W'($urandom);
      pwm_en   = 1'b1;
      PAT      = rpat;
      duty_num = 8'd255;
      pushBurst(rpat, 255);
      @(negedge clk);
      pwm_en = 1'b0;
      for (int i = 0; i < 99; i++) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      #1;
      checkOutput("reset_abort", mkExp(1'b0, 1'b0, 1'b0), mkExp(pwm_out, busy, valid));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      idleCycles(3);

      // Full-length burst after the abort
      applyStimulus(16'hC3A5, 255, 1'b1);
      idleCycles(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
